// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock_fpga,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       clock_key,
  input  logic       data_key,
  output logic       clock_key_oe,
  output logic       data_key_oe,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1048575) begin : g_chk
    $error("TIMEOUT_CYCLES must fit the 20-bit watchdog");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_SEND,
    S_ACK,
    S_WAIT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]    r_clk_sync;
  logic [2:0]    r_dat_sync;
  logic [9:0]    r_frame;
  logic          r_dout;
  logic [3:0]    r_edges;
  logic [IW-1:0] r_inh;

  logic w_fall;
  logic w_clk;
  logic w_dat;
  logic w_tmo;
  logic w_act;

  assign w_fall = (r_clk_sync[2:1] == 2'b10);
  assign w_clk  = r_clk_sync[2];
  assign w_dat  = r_dat_sync[2];
  assign w_act  = (r_state == S_START) || (r_state == S_SEND) ||
                  (r_state == S_ACK)   || (r_state == S_WAIT);

`ifdef PS2_TX_TIMEOUT_EN
  logic [19:0] r_wdog;

  always_ff @(posedge clock_fpga or posedge reset) begin
    if (reset) begin
      r_wdog <= '0;
    end else if (r_state == S_INHIBIT && w_next == S_START) begin
      r_wdog <= '0;
    end else if (w_act) begin
      r_wdog <= r_wdog + 20'd1;
    end
  end

  assign w_tmo = w_act && (r_wdog == 20'(TIMEOUT_CYCLES));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clock_fpga or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_clk_sync <= 3'b111;
      r_dat_sync <= 3'b111;
    end else begin
      r_state    <= w_next;
      r_clk_sync <= {r_clk_sync[1:0], clock_key};
      r_dat_sync <= {r_dat_sync[1:0], data_key};
    end
  end

  always_ff @(posedge clock_fpga or posedge reset) begin
    if (reset) begin
      r_frame <= '0;
      r_dout  <= 1'b0;
      r_edges <= '0;
      r_inh   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (tx_valid) begin
            r_frame <= {1'b1, ~^tx_data, tx_data};
            r_edges <= '0;
            r_inh   <= '0;
          end
        end
        S_INHIBIT: r_inh <= r_inh + 1'b1;
        S_START:   r_dout <= 1'b1;
        S_SEND: begin
          // each falling edge presents the next frame bit, LSB first
          if (w_fall) begin
            r_dout  <= ~r_frame[0];
            r_frame <= {1'b0, r_frame[9:1]};
            if (r_edges != 4'd11) r_edges <= r_edges + 4'd1;
          end
        end
        S_ACK: begin
          if (w_fall && r_edges != 4'd11) r_edges <= r_edges + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next   = r_state;
    tx_done  = 1'b0;
    tx_error = 1'b0;
    unique case (r_state)
      S_IDLE:    if (tx_valid) w_next = S_INHIBIT;
      S_INHIBIT: if (r_inh == IW'(INHIBIT_CYCLES - 1)) w_next = S_START;
      S_START:   w_next = S_SEND;
      S_SEND:    if (w_fall && r_edges == 4'd9) w_next = S_ACK;
      S_ACK: begin
        if (w_fall) begin
          if (!w_dat) begin
            w_next = S_WAIT;
          end else begin
            tx_error = 1'b1;
            w_next   = S_IDLE;
          end
        end
      end
      S_WAIT: begin
        if (w_clk && w_dat) begin
          tx_done = 1'b1;
          w_next  = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (w_tmo) begin
      tx_done  = 1'b0;
      tx_error = 1'b1;
      w_next   = S_IDLE;
    end
  end

  assign tx_ready     = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign clock_key_oe = ((r_state == S_INHIBIT) || (r_state == S_START)) & ~w_tmo;
  assign data_key_oe  = ((r_state == S_START) ||
                         (r_state == S_SEND && r_dout)) & ~w_tmo;

endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
- Host-to-device PS/2 transmitter; companion to the existing PS/2 receiver on the same clock_key/data_key pins.
- Sends 8-bit commands to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset.
- Drives the pins open-drain through output-enable signals; top level ties each pin to 0 when its _oe is 1, high-Z otherwise.
- Runs entirely in clock_fpga domain; PS/2 inputs pass through a 3-flop synchronizer.

Parameters:
- INHIBIT_CYCLES, 5000: clock_fpga cycles clock_key is held low before the request (100 us @ 50 MHz).
- TIMEOUT_CYCLES, 1000000: watchdog limit from request to frame end (20 ms @ 50 MHz); used only with PS2_TX_TIMEOUT_EN.

Ports:
- clock_fpga  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- tx_data  in  8  byte to send; sampled on accept
- tx_valid  in  1  request strobe
- tx_ready  out  1  high only in IDLE; accept = tx_valid & tx_ready
- clock_key  in  1  PS/2 clock pin, read back
- data_key  in  1  PS/2 data pin, read back
- clock_key_oe  out  1  1 = pull PS/2 clock low
- data_key_oe  out  1  1 = pull PS/2 data low
- tx_done  out  1  one-cycle pulse: frame sent and acknowledged
- tx_error  out  1  one-cycle pulse: missing ACK or timeout
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values (asynchronous): state IDLE; clock_key_oe=0, data_key_oe=0, tx_done=0, tx_error=0, busy=0, tx_ready=1. Synchronizers reset to 3'b111.
- Falling edge of the synced clock = sync[2:1]==2'b10, as in the receiver.
- Frame register = {stop=1, parity=~^tx_data, tx_data[7:0]}, sent LSB first. Parity is odd.
- IDLE: both oe=0. On accept (cycle N), latch frame, clear edge counter, go INHIBIT. clock_key_oe=1 from cycle N+1.
- INHIBIT: clock_key_oe=1 for exactly INHIBIT_CYCLES cycles, then go START.
- START, 1 cycle: clock_key_oe=1 and data_key_oe=1, so data falls before clock is released. Then go SEND.
- SEND: clock_key_oe=0; data_key_oe holds the start bit (1) until the first synced falling edge.
  - Falling edges 1..10 each shift out the next frame bit: data_key_oe = ~bit. Edges 1-8 carry data[0..7], edge 9 parity, edge 10 stop (oe=0).
  - After edge 10, go ACK.
- ACK: on the 11th falling edge, sample synced data.
  - Low: go WAIT_IDLE.
  - High: tx_error pulse, go IDLE.
- WAIT_IDLE: wait until synced clock and data are both high for 1 cycle, then tx_done pulse and go IDLE.
- tx_ready is combinational (state==IDLE). tx_valid is ignored outside IDLE; nothing is queued.
- tx_done and tx_error are never asserted together. tx_ready returns to 1 the cycle after either pulse.
- Falling edges in IDLE or INHIBIT are ignored; the receiver handles incoming traffic.
- Reset mid-frame: both oe drop to 0 immediately and asynchronously; no done/error pulse.
- Edge counter is 4 bits, 0..11, and saturates; it never wraps within a frame.

Optional Feature:
- Macro PS2_TX_TIMEOUT_EN.
- Defined: a 20-bit watchdog clears on entering START and increments each cycle in START, SEND, ACK, WAIT_IDLE. On reaching TIMEOUT_CYCLES: both oe=0, tx_error pulse, go IDLE in the same cycle.
- Not defined: no watchdog logic. The block waits indefinitely for device clocks; only reset recovers.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz that ACKs.
  - clock_key_oe low for 5000 cycles.
  - Device samples start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once; tx_error stays 0; tx_ready returns 1.
- Send 0xF4 -> device sees parity 0. Send 0xFF -> parity 1. Both complete with tx_done.
- Device never pulls data low on the 11th edge -> tx_error pulses for 1 cycle; no tx_done; both oe=0 afterwards.
- tx_valid held high in SEND with tx_data changing -> transmitted byte is the first latched value; a second frame starts only after return to IDLE.
- reset asserted at edge 5 of the frame -> clock_key_oe=data_key_oe=0 without waiting for a clock edge. After release, a new 0x55 request completes normally.
- With PS2_TX_TIMEOUT_EN and TIMEOUT_CYCLES=2000: device never clocks -> tx_error pulses exactly 2000 cycles after START. Without the macro, busy stays 1.
